kmac_state_reader: RTL and testbench

Parametrised successor to the KMAC state read window. It snapshots the Keccak state (all masking shares) on request and serves it by two paths: single-word random-access reads with one-cycle latency, and an auto-incrementing streaming readout with valid/ready backpressure. Either path can return one raw share or the unmasked (XOR-combined) state, with optional per-word endian swap. It sits between `sha3`/`kmac_core` and the register/DMA front end, and adds zeroisation and error reporting.

---
 rtl/kmac_pkg.sv | 20 ++
 rtl/kmac_state_word_sel.sv | 66 ++++++
 rtl/kmac_state_reader.sv | 186 ++++++++++++++++++
 tb/tb_kmac_state_reader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmac_pkg.sv
// Shared KMAC definitions for the state read window:
// read-word sizing, reader FSM states and the unmasked selector.
package kmac_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    HELD,
    STREAM
  } staterd_st_e;

  function automatic int state_rd_words(int state_w, int data_w);
    return (state_w + data_w - 1) / data_w;
  endfunction

  // The selector value one past the last raw share picks the XOR of all shares
  function automatic int state_rd_sel_unmasked(int share);
    return share;
  endfunction

endpackage

// File: rtl/kmac_state_word_sel.sv
// Combinational word picker: slice, share mux/XOR, zero pad,
// optional byte reversal of the selected word.
module kmac_state_word_sel
  import kmac_pkg::*;
#(
  parameter  int StateW   = 1600,
  parameter  int DataW    = 32,
  parameter  int Share    = 2,
  localparam int NumWords = state_rd_words(StateW, DataW),
  localparam int WordIdxW = $clog2(NumWords),
  localparam int SelW     = $clog2(Share + 1)
) (
  input  logic [StateW-1:0]   snap_i [Share],
  input  logic [SelW-1:0]     sel_i,
  input  logic [WordIdxW-1:0] word_i,
  input  logic                swap_i,
  output logic [DataW-1:0]    data_o,
  output logic                oor_o
);

  localparam int PadW = NumWords * DataW;
  localparam logic [SelW-1:0] SelUnm =
    SelW'(state_rd_sel_unmasked(Share));
  localparam logic [WordIdxW:0] NumW =
    (WordIdxW + 1)'(NumWords);

  logic [DataW-1:0] w_words [Share][NumWords];
  logic             w_raw;
  logic             w_unm;
  logic             w_word_ok;
  logic [DataW-1:0] w_mix;

  for (genvar s = 0; s < Share; s++) begin : g_share
    logic [PadW-1:0] w_pad;
    assign w_pad = PadW'(snap_i[s]);
    for (genvar k = 0; k < NumWords; k++) begin : g_word
      assign w_words[s][k] = w_pad[k*DataW +: DataW];
    end
  end

  assign w_raw     = sel_i < SelUnm;
  assign w_unm     = (Share > 1) && (sel_i == SelUnm);
  assign w_word_ok = {1'b0, word_i} < NumW;
  assign oor_o     = ~((w_raw | w_unm) & w_word_ok);

  always_comb begin
    w_mix = '0;
    if (!oor_o) begin
      for (int s = 0; s < Share; s++) begin
        if (w_unm || sel_i == SelW'(s)) begin
          w_mix = w_mix ^ w_words[s][word_i];
        end
      end
    end
  end

  always_comb begin
    data_o = w_mix;
    if (swap_i) begin
      for (int b = 0; b < DataW / 8; b++) begin
        data_o[8*b +: 8] = w_mix[DataW-8-8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/kmac_state_reader.sv
// Keccak state snapshot window: random word reads plus an
// auto-incrementing valid/ready stream, with zeroisation.
module kmac_state_reader
  import kmac_pkg::*;
#(
  parameter  int StateW   = 1600,
  parameter  int DataW    = 32,
  parameter  int Share    = 2,
  localparam int NumWords = state_rd_words(StateW, DataW),
  localparam int WordIdxW = $clog2(NumWords),
  localparam int SelW     = $clog2(Share + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [StateW-1:0]        state_i [Share],
  input  logic                     state_valid_i,
  input  logic                     snap_req_i,
  output logic                     snap_done_o,
  input  logic                     clear_i,
  input  logic                     endian_swap_i,
  input  logic                     rd_req_i,
  output logic                     rd_gnt_o,
  input  logic [SelW+WordIdxW-1:0] rd_addr_i,
  output logic                     rd_rvalid_o,
  output logic [DataW-1:0]         rd_rdata_o,
  output logic                     rd_rerror_o,
  input  logic                     strm_start_i,
  input  logic [SelW-1:0]          strm_sel_i,
  output logic                     strm_valid_o,
  input  logic                     strm_ready_i,
  output logic [DataW-1:0]         strm_data_o,
  output logic                     strm_last_o,
  output logic                     busy_o
);

  localparam int StateRdSelUnmasked =
    state_rd_sel_unmasked(Share);
  localparam logic [SelW-1:0] SelMax =
    SelW'(Share > 1 ? StateRdSelUnmasked : Share - 1);
  localparam logic [WordIdxW-1:0] LastWord =
    WordIdxW'(NumWords - 1);

  staterd_st_e r_st;
  staterd_st_e w_st_nxt;

  logic [StateW-1:0]   r_snap [Share];
  logic [WordIdxW-1:0] r_cnt;
  logic [SelW-1:0]     r_strm_sel;
  logic                r_strm_swap;
  logic                r_snap_done;
  logic                r_rvalid;
  logic [DataW-1:0]    r_rdata;
  logic                r_rerror;

  logic             w_cap;
  logic             w_start;
  logic             w_beat;
  logic             w_last;
  logic             w_sel_ok;
  logic             w_rd_err;
  logic             w_rd_oor;
  logic             w_strm_oor;
  logic [DataW-1:0] w_rd_data;
  logic [DataW-1:0] w_strm_data;

  kmac_state_word_sel #(
    .StateW (StateW),
    .DataW  (DataW),
    .Share  (Share)
  ) u_rd_sel (
    .snap_i (r_snap),
    .sel_i  (rd_addr_i[SelW+WordIdxW-1 -: SelW]),
    .word_i (rd_addr_i[WordIdxW-1:0]),
    .swap_i (endian_swap_i),
    .data_o (w_rd_data),
    .oor_o  (w_rd_oor)
  );

  kmac_state_word_sel #(
    .StateW (StateW),
    .DataW  (DataW),
    .Share  (Share)
  ) u_strm_sel (
    .snap_i (r_snap),
    .sel_i  (r_strm_sel),
    .word_i (r_cnt),
    .swap_i (r_strm_swap),
    .data_o (w_strm_data),
    .oor_o  (w_strm_oor)
  );

  assign w_sel_ok = strm_sel_i <= SelMax;
  assign w_beat   = strm_valid_o & strm_ready_i;
  assign w_last   = r_cnt == LastWord;
  assign w_rd_err = w_rd_oor | (r_st == EMPTY);

  always_comb begin
    w_st_nxt = r_st;
    w_cap    = 1'b0;
    w_start  = 1'b0;
    unique case (r_st)
      EMPTY: begin
        if (snap_req_i && state_valid_i) begin
          w_cap    = 1'b1;
          w_st_nxt = HELD;
        end
      end
      HELD: begin
        w_cap = snap_req_i & state_valid_i;
        if (strm_start_i && w_sel_ok) begin
          w_start  = 1'b1;
          w_st_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_beat && w_last) w_st_nxt = HELD;
      end
      default: w_st_nxt = EMPTY;
    endcase
    // Zeroisation overrides everything else this cycle
    if (clear_i) begin
      w_st_nxt = EMPTY;
      w_cap    = 1'b0;
      w_start  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_st <= EMPTY;
    else       r_st <= w_st_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < Share; s++) r_snap[s] <= '0;
    end else if (clear_i) begin
      for (int s = 0; s < Share; s++) r_snap[s] <= '0;
    end else if (w_cap) begin
      for (int s = 0; s < Share; s++) r_snap[s] <= state_i[s];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_strm_sel  <= '0;
      r_strm_swap <= 1'b0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt       <= '0;
      r_strm_sel  <= strm_sel_i;
      r_strm_swap <= endian_swap_i;
    end else if (w_beat) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_snap_done <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rerror    <= 1'b0;
    end else begin
      r_snap_done <= w_cap;
      r_rvalid    <= rd_gnt_o;
      if (rd_gnt_o) begin
        r_rerror <= w_rd_err;
        r_rdata  <= w_rd_err ? '0 : w_rd_data;
      end
    end
  end

  assign rd_gnt_o     = rd_req_i & (r_st != STREAM);
  assign rd_rvalid_o  = r_rvalid;
  assign rd_rdata_o   = r_rdata;
  assign rd_rerror_o  = r_rerror;
  assign snap_done_o  = r_snap_done;
  assign strm_valid_o = r_st == STREAM;
  assign busy_o       = r_st == STREAM;
  assign strm_last_o  = strm_valid_o & w_last;
  assign strm_data_o  =
    (strm_valid_o & ~w_strm_oor) ? w_strm_data : '0;

endmodule

// File: tb/tb_kmac_state_reader.sv
// Directed bench: a 32-bit/2-share instance for reads and clear,
// a 64-bit/1-share instance for the backpressured stream.
module tb_kmac_state_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Instance A: StateW=1600, DataW=32, Share=2
  logic [1599:0] a_state [2];
  logic a_state_valid, a_snap_req, a_snap_done, a_clear, a_swap;
  logic a_rd_req, a_gnt, a_rvalid, a_rerror;
  logic [7:0]  a_addr;
  logic [31:0] a_rdata;
  logic a_start, a_valid, a_ready, a_last, a_busy;
  logic [1:0]  a_sel;
  logic [31:0] a_sdata;

  // Instance B: StateW=1600, DataW=64, Share=1
  logic [1599:0] b_state [1];
  logic b_state_valid, b_snap_req, b_snap_done, b_clear, b_swap;
  logic b_rd_req, b_gnt, b_rvalid, b_rerror;
  logic [5:0]  b_addr;
  logic [63:0] b_rdata;
  logic b_start, b_valid, b_ready, b_last, b_busy;
  logic [0:0]  b_sel;
  logic [63:0] b_sdata;

  kmac_state_reader #(
    .StateW (1600),
    .DataW  (32),
    .Share  (2)
  ) u_a (
    .clk_i         (clk),
    .rst_i         (rst),
    .state_i       (a_state),
    .state_valid_i (a_state_valid),
    .snap_req_i    (a_snap_req),
    .snap_done_o   (a_snap_done),
    .clear_i       (a_clear),
    .endian_swap_i (a_swap),
    .rd_req_i      (a_rd_req),
    .rd_gnt_o      (a_gnt),
    .rd_addr_i     (a_addr),
    .rd_rvalid_o   (a_rvalid),
    .rd_rdata_o    (a_rdata),
    .rd_rerror_o   (a_rerror),
    .strm_start_i  (a_start),
    .strm_sel_i    (a_sel),
    .strm_valid_o  (a_valid),
    .strm_ready_i  (a_ready),
    .strm_data_o   (a_sdata),
    .strm_last_o   (a_last),
    .busy_o        (a_busy)
  );

  kmac_state_reader #(
    .StateW (1600),
    .DataW  (64),
    .Share  (1)
  ) u_b (
    .clk_i         (clk),
    .rst_i         (rst),
    .state_i       (b_state),
    .state_valid_i (b_state_valid),
    .snap_req_i    (b_snap_req),
    .snap_done_o   (b_snap_done),
    .clear_i       (b_clear),
    .endian_swap_i (b_swap),
    .rd_req_i      (b_rd_req),
    .rd_gnt_o      (b_gnt),
    .rd_addr_i     (b_addr),
    .rd_rvalid_o   (b_rvalid),
    .rd_rdata_o    (b_rdata),
    .rd_rerror_o   (b_rerror),
    .strm_start_i  (b_start),
    .strm_sel_i    (b_sel),
    .strm_valid_o  (b_valid),
    .strm_ready_i  (b_ready),
    .strm_data_o   (b_sdata),
    .strm_last_o   (b_last),
    .busy_o        (b_busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 64-bit word e of the incrementing-byte pattern
  function automatic logic [63:0] bword(int e);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = 8'(8*e + j);
    return v;
  endfunction

  int e;
  bit rdy;

  initial begin
    rst = 1'b1;
    {a_state_valid, a_snap_req, a_clear, a_swap} = '0;
    {a_rd_req, a_start, a_ready} = '0;
    a_addr = '0;
    a_sel  = '0;
    {b_state_valid, b_snap_req, b_clear, b_swap} = '0;
    {b_rd_req, b_start, b_ready} = '0;
    b_addr = '0;
    b_sel  = '0;
    for (int k = 0; k < 200; k++) begin
      a_state[0][8*k +: 8] = 8'hA5;
      a_state[1][8*k +: 8] = 8'(k);
      b_state[0][8*k +: 8] = 8'(k);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_rerror", a_rerror, 0);
    chk("rst_snap_done", a_snap_done, 0);
    chk("rst_strm_valid", a_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_b_sdata", b_sdata, 0);
    chk("rst_b_last", b_last, 0);
    rst = 1'b0;
    tick();

    a_rd_req = 1'b1;
    a_addr   = {2'd0, 6'd0};
    #1;
    chk("gnt_empty", a_gnt, 1);
    tick();
    a_rd_req = 1'b0;
    chk("empty_rvalid", a_rvalid, 1);
    chk("empty_rdata", a_rdata, 0);
    chk("empty_rerror", a_rerror, 1);
    tick();
    chk("rvalid_drop", a_rvalid, 0);

    a_snap_req = 1'b1;
    b_snap_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_capture", a_snap_done, 0);
    end
    a_state_valid = 1'b1;
    b_state_valid = 1'b1;
    tick();
    {a_snap_req, a_state_valid, b_snap_req, b_state_valid} = '0;
    chk("snap_done_a", a_snap_done, 1);
    chk("snap_done_b", b_snap_done, 1);
    tick();
    chk("snap_done_pulse", a_snap_done, 0);

    a_rd_req = 1'b1;
    a_addr   = {2'd0, 6'd3};
    tick();
    chk("rd_s0_w3", a_rdata, 64'hA5A5A5A5);
    chk("rd_s0_w3_err", a_rerror, 0);
    chk("rd_s0_w3_vld", a_rvalid, 1);
    a_addr = {2'd1, 6'd0};
    tick();
    chk("rd_s1_w0", a_rdata, 64'h03020100);
    chk("rd_s1_w0_err", a_rerror, 0);
    a_addr = {2'd1, 6'd49};
    tick();
    chk("rd_s1_w49", a_rdata, 64'hC7C6C5C4);
    a_addr = {2'd2, 6'd0};
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    chk("rd_unm_swap", a_rdata, 64'hA5A4A7A6);
    a_addr = {2'd0, 6'd50};
    tick();
    chk("rd_word50_data", a_rdata, 0);
    chk("rd_word50_err", a_rerror, 1);
    a_addr = {2'd3, 6'd0};
    tick();
    chk("rd_sel3_data", a_rdata, 0);
    chk("rd_sel3_err", a_rerror, 1);

    a_state[0]    = '0;
    a_snap_req    = 1'b1;
    a_state_valid = 1'b1;
    a_addr        = {2'd0, 6'd3};
    tick();
    a_snap_req    = 1'b0;
    a_state_valid = 1'b0;
    chk("recap_same_cycle", a_rdata, 64'hA5A5A5A5);
    tick();
    chk("recap_next", a_rdata, 0);
    chk("recap_next_err", a_rerror, 0);
    a_addr = {2'd2, 6'd0};
    tick();
    a_rd_req = 1'b0;
    chk("rd_unm_noswap", a_rdata, 64'h03020100);

    b_rd_req = 1'b1;
    b_addr   = {1'b1, 5'd0};
    tick();
    chk("b_unm_illegal", b_rerror, 1);
    b_addr = {1'b0, 5'd24};
    tick();
    b_rd_req = 1'b0;
    chk("b_rd_w24", b_rdata, bword(24));
    chk("b_rd_w24_err", b_rerror, 0);

    a_start = 1'b1;
    a_sel   = 2'd3;
    tick();
    a_start = 1'b0;
    chk("bad_sel_start", a_valid, 0);

    a_sel   = 2'd1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_strm_valid", a_valid, 1);
    chk("a_strm_busy", a_busy, 1);
    chk("a_strm_w0", a_sdata, 64'h03020100);
    chk("a_strm_last0", a_last, 0);
    a_rd_req = 1'b1;
    #1;
    chk("gnt_in_stream", a_gnt, 0);
    a_rd_req = 1'b0;
    a_ready  = 1'b1;
    repeat (10) tick();
    chk("a_strm_w10", a_sdata, 64'h2B2A2928);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    a_ready = 1'b0;
    chk("clr_valid", a_valid, 0);
    chk("clr_busy", a_busy, 0);
    a_rd_req = 1'b1;
    a_addr   = {2'd1, 6'd0};
    tick();
    a_rd_req = 1'b0;
    chk("clr_rd_data", a_rdata, 0);
    chk("clr_rd_err", a_rerror, 1);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("start_after_clr", a_valid, 0);

    a_snap_req    = 1'b1;
    a_state_valid = 1'b1;
    tick();
    a_snap_req    = 1'b0;
    a_state_valid = 1'b0;
    a_rd_req = 1'b1;
    a_addr   = {2'd1, 6'd0};
    a_clear  = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("clr_mid_rd_data", a_rdata, 64'h03020100);
    chk("clr_mid_rd_err", a_rerror, 0);
    tick();
    a_rd_req = 1'b0;
    chk("post_clr_rd_data", a_rdata, 0);
    chk("post_clr_rd_err", a_rerror, 1);

    b_sel   = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    e   = 0;
    rdy = 1'b0;
    for (int c = 0; c < 80 && e < 25; c++) begin
      b_ready = rdy;
      chk("b_valid", b_valid, 1);
      chk("b_data", b_sdata, bword(e));
      chk("b_last", b_last, (e == 24) ? 1 : 0);
      tick();
      if (rdy) e++;
      rdy = ~rdy;
    end
    b_ready = 1'b0;
    chk("b_beats", e, 25);
    chk("b_busy_end", b_busy, 0);
    chk("b_valid_end", b_valid, 0);

    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_restart", b_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", b_valid, 0);
    chk("arst_busy", b_busy, 0);
    chk("arst_sdata", b_sdata, 0);
    chk("arst_a_rerror", a_rerror, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
